mem_dma_copy: RTL
=================

Name: mem_dma_copy

Overview:
- Initiator-side block-transfer engine that drives the single-port data memory interface (address, write enable, write data, asynchronous read data).
- Copies a block of words from a source address range to a destination range, or fills a destination range with a constant.
- Sits beside the core as a memory-side helper for bulk initialisation and copies. The core must not access data memory while o_busy is high.

Parameters:
p_WORD_LEN, 16, bits per memory word
p_ADDR_LEN, 10, memory address width; memory holds 2**p_ADDR_LEN words

Ports:
i_clk  input  1  clock; all state changes on posedge
i_rst_n  input  1  reset, asynchronous, active-low
i_start  input  1  request a transfer; sampled only in IDLE
i_mode  input  1  0 = copy, 1 = fill
i_src  input  p_ADDR_LEN  source start address (copy only)
i_dst  input  p_ADDR_LEN  destination start address
i_len  input  p_ADDR_LEN+1  word count, 0 to 2**p_ADDR_LEN
i_fill_data  input  p_WORD_LEN  fill constant (fill only)
o_busy  output  1  high in READ and WRITE states
o_done  output  1  one-cycle completion pulse
o_mem_addr  output  p_ADDR_LEN  memory address
o_mem_wr_en  output  1  memory write enable
o_mem_wr_data  output  p_WORD_LEN  memory write data
i_mem_rd_data  input  p_WORD_LEN  asynchronous memory read data

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State = IDLE.
  - o_busy = 0, o_done = 0, o_mem_wr_en = 0, o_mem_addr = 0, o_mem_wr_data = 0.
  - Internal pointers, counter and buffer = 0.
- States: IDLE, READ, WRITE, DONE. All outputs decode from registered state and registers only; there is no combinational path from any input to any output.
- IDLE:
  - o_mem_wr_en = 0, o_mem_addr = 0.
  - On a posedge with i_start = 1: latch i_mode, i_src, i_dst, i_len and i_fill_data.
  - Next state:
    - i_len == 0 → DONE.
    - mode = copy → READ.
    - mode = fill → WRITE.
- READ (copy only):
  - o_mem_addr = src pointer, o_mem_wr_en = 0.
  - At posedge: buffer ← i_mem_rd_data; go to WRITE.
- WRITE:
  - o_mem_addr = dst pointer, o_mem_wr_en = 1.
  - o_mem_wr_data = buffer (copy) or latched fill value (fill).
  - At posedge:
    - src and dst pointers increment modulo 2**p_ADDR_LEN (wrap from max address to 0).
    - Count decrements.
    - If count was 1 → DONE; otherwise → READ (copy) or stay in WRITE (fill).
- DONE:
  - o_done = 1, o_busy = 0, o_mem_wr_en = 0.
  - Unconditionally → IDLE on the next posedge.
- o_done is high in DONE only, so it pulses for exactly one cycle.
- Latency, with the start sampled at edge E0:
  - Copy of N words: 2N cycles busy; o_done high between edges E2N and E2N+1.
  - Fill of N words: N cycles busy; o_done high between EN and EN+1.
  - Length 0: o_done high between E0 and E1; no memory write occurs.
- i_start while not in IDLE (including DONE) is ignored. Parameter inputs are only sampled at start, so later changes have no effect.
- Overlapping copy ranges: always proceeds in ascending address order, word by word. When dst > src and the ranges overlap, source words are overwritten before they are read. This is the defined behaviour; no memmove semantics.
- Full-memory transfer: i_len = 2**p_ADDR_LEN is legal. The count register is p_ADDR_LEN+1 bits wide, and every address is visited exactly once.
- Reset asserted mid-transfer: aborts immediately; o_mem_wr_en drops at once; no o_done pulse. Words already written remain written.

Test Plan:
- Fill:
  - Stimulus: reset, then start with mode = 1, dst = 0x010, len = 4, fill = 0xBEEF.
  - Required: writes to 0x010 through 0x013 on 4 consecutive cycles; o_busy high for 4 cycles; o_done high for exactly 1 cycle; memory reads back 0xBEEF at 0x010–0x013 and 0x0000 at 0x014.
- Copy:
  - Stimulus: preload 0x020–0x022 = 0x1111, 0x2222, 0x3333; start with mode = 0, src = 0x020, dst = 0x100, len = 3.
  - Required: o_mem_wr_en alternates 0,1,0,1,0,1; o_done high 7 cycles after the start edge; 0x100–0x102 hold the same three values.
- Wrap:
  - Stimulus: fill with dst = 0x3FE, len = 4, value 0x00AA.
  - Required: addresses 0x3FE, 0x3FF, 0x000, 0x001 are written; 0x002 stays 0.
- Zero length and ignored start:
  - Stimulus: start with len = 0.
  - Required: no write occurs; o_done pulses 1 cycle after the start edge.
  - Stimulus: during a copy of len = 5, pulse i_start with different parameters.
  - Required: the transfer is unaffected; exactly one o_done pulse.
- Overlap:
  - Stimulus: preload 0x040–0x042 = 1, 2, 3; copy src = 0x040, dst = 0x041, len = 2.
  - Required: 0x041 = 1, 0x042 = 1.
- Reset mid-operation:
  - Stimulus: assert i_rst_n low during the 3rd write of a 6-word fill.
  - Required: o_mem_wr_en = 0 and o_busy = 0 immediately, with no clock edge needed; no o_done; only the first 2 words are written. After release, a new start works normally.

Source files
------------

// File: rtl/mem_dma_copy.sv
`default_nettype none
// ============================================================================
// Module      : mem_dma_copy
// Description : Block copy / fill engine driving a single-port data memory
//               with asynchronous read data.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_dma_copy #(
  parameter int p_WORD_LEN = 16,
  parameter int p_ADDR_LEN = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_mode,
  input  logic [p_ADDR_LEN-1:0] i_src,
  input  logic [p_ADDR_LEN-1:0] i_dst,
  input  logic [p_ADDR_LEN:0]   i_len,
  input  logic [p_WORD_LEN-1:0] i_fill_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [p_ADDR_LEN-1:0] o_mem_addr,
  output logic                  o_mem_wr_en,
  output logic [p_WORD_LEN-1:0] o_mem_wr_data,
  input  logic [p_WORD_LEN-1:0] i_mem_rd_data
);

  localparam logic [p_ADDR_LEN-1:0] c_ADDR_ONE = 1;
  localparam logic [p_ADDR_LEN:0]   c_CNT_ONE  = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_mode;
  logic [p_ADDR_LEN-1:0] r_src;
  logic [p_ADDR_LEN-1:0] r_dst;
  logic [p_ADDR_LEN:0]   r_cnt;

  // o_mem_wr_data doubles as the word buffer: it holds the fetched word in
  // copy mode and the latched constant in fill mode.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_mode        <= 1'b0;
      r_src         <= '0;
      r_dst         <= '0;
      r_cnt         <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_mem_addr    <= '0;
      o_mem_wr_en   <= 1'b0;
      o_mem_wr_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          o_busy      <= 1'b0;
          o_done      <= 1'b0;
          o_mem_wr_en <= 1'b0;
          o_mem_addr  <= '0;
          if (i_start) begin
            r_mode <= i_mode;
            r_src  <= i_src;
            r_dst  <= i_dst;
            r_cnt  <= i_len;
            if (i_len == '0) begin
              r_state <= S_DONE;
              o_done  <= 1'b1;
            end else if (!i_mode) begin
              r_state    <= S_READ;
              o_busy     <= 1'b1;
              o_mem_addr <= i_src;
            end else begin
              r_state       <= S_WRITE;
              o_busy        <= 1'b1;
              o_mem_addr    <= i_dst;
              o_mem_wr_en   <= 1'b1;
              o_mem_wr_data <= i_fill_data;
            end
          end
        end

        S_READ: begin
          r_state       <= S_WRITE;
          o_mem_addr    <= r_dst;
          o_mem_wr_en   <= 1'b1;
          o_mem_wr_data <= i_mem_rd_data;
        end

        S_WRITE: begin
          r_src <= r_src + c_ADDR_ONE;
          r_dst <= r_dst + c_ADDR_ONE;
          r_cnt <= r_cnt - c_CNT_ONE;
          if (r_cnt == c_CNT_ONE) begin
            r_state     <= S_DONE;
            o_busy      <= 1'b0;
            o_done      <= 1'b1;
            o_mem_wr_en <= 1'b0;
            o_mem_addr  <= '0;
          end else if (!r_mode) begin
            r_state     <= S_READ;
            o_mem_wr_en <= 1'b0;
            o_mem_addr  <= r_src + c_ADDR_ONE;
          end else begin
            o_mem_addr <= r_dst + c_ADDR_ONE;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          o_done  <= 1'b0;
        end

        default: begin
          r_state     <= S_IDLE;
          o_busy      <= 1'b0;
          o_done      <= 1'b0;
          o_mem_wr_en <= 1'b0;
          o_mem_addr  <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
